// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES-128 round sequencer (optional AES_SEQ_PERF_EN adds BLOCK_COUNT/STALL_COUNT)
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int RC_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [127:0]    IN_DATA,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [127:0]    OUT_DATA,
  input  logic            ABORT,
  output logic            RK_REQ,
  output logic [RC_W-1:0] RK_IDX,
  input  logic            RK_VALID,
  input  logic [127:0]    RK_DATA,
  output logic [127:0]    DP_IN,
  output logic            DP_LAST,
  input  logic [127:0]    DP_OUT,
  output logic            BUSY
`ifdef AES_SEQ_PERF_EN
  ,
  output logic [31:0]     BLOCK_COUNT,
  output logic [31:0]     STALL_COUNT
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [RC_W-1:0] LAST_RC = RC_W'(NUM_ROUNDS);

  state_t          st;
  state_t          st_nxt;
  logic [127:0]    state_q;
  logic [127:0]    out_q;
  logic [RC_W-1:0] round_q;
  logic            last_round;
  logic [127:0]    key_added;

  assign last_round = (round_q == LAST_RC);
  // Round 0 is the bare initial key add; later rounds add the key to the datapath result.
  assign key_added  = ((round_q == '0) ? state_q : DP_OUT) ^ RK_DATA;

  assign RK_IDX   = round_q;
  assign DP_IN    = state_q;
  // A separate output register lets OUT_DATA survive the next block's capture into state_q.
  assign OUT_DATA = out_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) st <= S_IDLE;
    else     st <= st_nxt;
  end

  // Next-state decode and handshake/status outputs; ABORT outranks RK_VALID and OUT_READY
  always_comb begin
    st_nxt    = st;
    IN_READY  = 1'b0;
    OUT_VALID = 1'b0;
    RK_REQ    = 1'b0;
    DP_LAST   = 1'b0;
    BUSY      = 1'b0;
    case (st)
      S_IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) st_nxt = S_BUSY;
      end
      S_BUSY: begin
        BUSY    = 1'b1;
        RK_REQ  = 1'b1;
        DP_LAST = last_round;
        if (ABORT)                       st_nxt = S_IDLE;
        else if (RK_VALID && last_round) st_nxt = S_DONE;
      end
      S_DONE: begin
        BUSY      = 1'b1;
        OUT_VALID = 1'b1;
        if (ABORT || OUT_READY) st_nxt = S_IDLE;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  // State register, round counter and ciphertext register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      out_q   <= '0;
      round_q <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (IN_VALID) begin
            state_q <= IN_DATA;
            round_q <= '0;
          end
        end
        S_BUSY: begin
          if (ABORT) begin
            round_q <= '0;
          end else if (RK_VALID) begin
            state_q <= key_added;
            if (last_round) out_q   <= key_added;
            else            round_q <= round_q + 1'b1;
          end
        end
        S_DONE: begin
          if (ABORT || OUT_READY) round_q <= '0;
        end
        default: round_q <= '0;
      endcase
    end
  end

`ifdef AES_SEQ_PERF_EN
  // Completed-block (wrapping) and key-stall (saturating) counters, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      BLOCK_COUNT <= '0;
      STALL_COUNT <= '0;
    end else begin
      if (st == S_DONE && OUT_READY && !ABORT) BLOCK_COUNT <= BLOCK_COUNT + 32'd1;
      if (st == S_BUSY && !RK_VALID && STALL_COUNT != 32'hFFFF_FFFF)
        STALL_COUNT <= STALL_COUNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - scoreboard bench for aes_round_sequencer with AES round/key model
module tb_aes_round_sequencer;

  logic         clk;
  logic         rst;
  logic         IN_VALID;
  logic         IN_READY;
  logic [127:0] IN_DATA;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [127:0] OUT_DATA;
  logic         ABORT;
  logic         RK_REQ;
  logic [3:0]   RK_IDX;
  logic         RK_VALID;
  logic [127:0] RK_DATA;
  logic [127:0] DP_IN;
  logic         DP_LAST;
  logic [127:0] DP_OUT;
  logic         BUSY;
`ifdef AES_SEQ_PERF_EN
  logic [31:0]  BLOCK_COUNT;
  logic [31:0]  STALL_COUNT;
`endif

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    logic [127:0] data;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] rk [0:1][0:15];
  int           n_tests;
  int           n_fail;
  int           cyc     = 0;
  int           n_acc   = 0;
  int           acc_cyc = 0;
  logic         blk_key = 1'b0;
  logic         cur_key;
  logic         stall_en;
  logic [15:0]  stall_mask;
  logic [15:0]  stalled = '0;
  logic         mon_en;

  aes_round_sequencer dut (
    .clk(clk), .rst(rst),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .ABORT(ABORT),
    .RK_REQ(RK_REQ), .RK_IDX(RK_IDX), .RK_VALID(RK_VALID), .RK_DATA(RK_DATA),
    .DP_IN(DP_IN), .DP_LAST(DP_LAST), .DP_OUT(DP_OUT),
    .BUSY(BUSY)
`ifdef AES_SEQ_PERF_EN
    , .BLOCK_COUNT(BLOCK_COUNT), .STALL_COUNT(STALL_COUNT)
`endif
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o;
  endfunction

  function automatic void expand(input logic ks, input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]) ^ rc, sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[ks][r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endfunction

  assign DP_OUT   = aes_round(DP_IN, DP_LAST);
  assign RK_VALID = !(stall_en && RK_REQ && stall_mask[RK_IDX] && !stalled[RK_IDX]);
  assign RK_DATA  = RK_VALID ? rk[blk_key][RK_IDX] : '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge bookkeeping: cycle count, accepted blocks, key of the block in flight, one-shot stalls
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (IN_VALID && IN_READY) begin
      n_acc   <= n_acc + 1;
      acc_cyc <= cyc + 1;
      blk_key <= cur_key;
    end
    if (!stall_en)                stalled         <= '0;
    else if (RK_REQ && !RK_VALID) stalled[RK_IDX] <= 1'b1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_blk(input logic [127:0] data, input int lat);
    exp_t e;
    e.data = data;
    e.lat  = lat;
    sb.push_back(e);
  endtask

  task automatic send(input logic [127:0] pt, input logic ks);
    int c;
    c        = n_acc;
    IN_DATA  = pt;
    cur_key  = ks;
    IN_VALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (n_acc != c) return;
    end
    timeout("accept");
  endtask

  task automatic wait_out();
    for (int i = 0; i < 100; i++) begin
      if (OUT_VALID) return;
      tick();
    end
    timeout("out_valid");
  endtask

  task automatic wait_idx(input logic [3:0] k);
    for (int i = 0; i < 100; i++) begin
      if (RK_REQ && RK_IDX == k) return;
      tick();
    end
    timeout("rk_idx");
  endtask

  task automatic check_reset();
    chk_int("rst_in_ready",  int'(IN_READY),  1);
    chk_int("rst_out_valid", int'(OUT_VALID), 0);
    chk("rst_out_data", OUT_DATA, '0);
    chk_int("rst_rk_req",    int'(RK_REQ),    0);
    chk_int("rst_rk_idx",    int'(RK_IDX),    0);
    chk_int("rst_dp_last",   int'(DP_LAST),   0);
    chk_int("rst_busy",      int'(BUSY),      0);
`ifdef AES_SEQ_PERF_EN
    chk_int("rst_block_count", int'(BLOCK_COUNT), 0);
    chk_int("rst_stall_count", int'(STALL_COUNT), 0);
`endif
  endtask

  // Pops the scoreboard on each new OUT_VALID and watches key-port rules every cycle
  task automatic monitor();
    exp_t       cur;
    logic       prev_ov;
    logic       prev_stall;
    logic [3:0] prev_idx;
    cur.data   = '0;
    cur.lat    = 0;
    prev_ov    = 1'b0;
    prev_stall = 1'b0;
    prev_idx   = '0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (OUT_VALID && !prev_ov) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got %h with no block expected", OUT_DATA);
          end else begin
            cur = sb.pop_front();
            chk("ciphertext", OUT_DATA, cur.data);
            chk_int("latency", cyc - acc_cyc, cur.lat);
          end
        end else if (OUT_VALID) begin
          chk("out_hold", OUT_DATA, cur.data);
        end
        if (RK_REQ) begin
          chk_int("rk_idx_range", int'(RK_IDX <= 4'd10), 1);
          chk_int("dp_last", int'(DP_LAST), int'(RK_IDX == 4'd10));
          if (prev_stall) chk_int("stall_idx_hold", int'(RK_IDX), int'(prev_idx));
        end
      end
      prev_ov    = OUT_VALID;
      prev_stall = RK_REQ && !RK_VALID;
      prev_idx   = RK_IDX;
    end
  endtask

  task automatic run_tests();
    int          c;
    int          a [4];
`ifdef AES_SEQ_PERF_EN
    logic [31:0] sc0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    check_reset();

    // FIPS-197 App. B, free-running keys
    expect_blk(CT_B, 11);
    send(PT_B, 1'b0);
    IN_VALID = 1'b0;
    wait_out();
    tick();
    chk_int("idle_after_hs", int'(IN_READY), 1);
    chk("out_data_kept", OUT_DATA, CT_B);

    // One-cycle key stalls in rounds 0, 5 and 10
`ifdef AES_SEQ_PERF_EN
    sc0 = STALL_COUNT;
`endif
    stall_en = 1'b1;
    expect_blk(CT_B, 14);
    send(PT_B, 1'b0);
    IN_VALID = 1'b0;
    wait_out();
    tick();
    stall_en = 1'b0;
`ifdef AES_SEQ_PERF_EN
    chk_int("stall_count", int'(STALL_COUNT - sc0), 3);
`endif

    // Output backpressure with a competing IN_VALID
    OUT_READY = 1'b0;
    expect_blk(CT_C, 11);
    send(PT_C, 1'b1);
    IN_VALID = 1'b0;
    wait_out();
    c        = n_acc;
    IN_DATA  = PT_B;
    cur_key  = 1'b0;
    IN_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_int("bp_in_ready", int'(IN_READY), 0);
      chk_int("bp_out_valid", int'(OUT_VALID), 1);
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    tick();
    chk_int("bp_release_in_ready", int'(IN_READY), 1);
    chk_int("bp_release_out_valid", int'(OUT_VALID), 0);
    chk("bp_out_data_kept", OUT_DATA, CT_C);
    chk_int("bp_no_accept", n_acc - c, 0);

    // ABORT at round 4, then a clean block
    send(PT_B, 1'b0);
    IN_VALID = 1'b0;
    wait_idx(4'd4);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk_int("abort_in_ready", int'(IN_READY), 1);
    chk_int("abort_busy", int'(BUSY), 0);
    chk_int("abort_out_valid", int'(OUT_VALID), 0);
    repeat (15) tick();
    expect_blk(CT_B, 11);
    send(PT_B, 1'b0);
    IN_VALID = 1'b0;
    wait_out();
    tick();

    // rst while DONE
    OUT_READY = 1'b0;
    expect_blk(CT_C, 11);
    send(PT_C, 1'b1);
    IN_VALID = 1'b0;
    wait_out();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset();
    OUT_READY = 1'b1;

    // rst while BUSY in round 7
    send(PT_B, 1'b0);
    IN_VALID = 1'b0;
    wait_idx(4'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset();

    // Four back-to-back blocks, alternating vectors, IN_VALID held high
    for (int k = 0; k < 4; k++) begin
      expect_blk((k % 2 == 0) ? CT_B : CT_C, 11);
      send((k % 2 == 0) ? PT_B : PT_C, (k % 2 == 1));
      a[k] = acc_cyc;
    end
    IN_VALID = 1'b0;
    for (int k = 1; k < 4; k++) chk_int("b2b_period", a[k] - a[k-1], 13);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    repeat (3) tick();
    chk_int("sb_drained", sb.size(), 0);
`ifdef AES_SEQ_PERF_EN
    chk_int("block_count", int'(BLOCK_COUNT), 4);
`endif
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    IN_VALID   = 1'b0;
    IN_DATA    = '0;
    OUT_READY  = 1'b1;
    ABORT      = 1'b0;
    stall_en   = 1'b0;
    stall_mask = 16'b0000_0100_0010_0001;
    cur_key    = 1'b0;
    mon_en     = 1'b0;
    expand(1'b0, KEY_B);
    expand(1'b1, KEY_C);
    fork
      monitor();
      run_tests();
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
